// File: rtl/acc_skip_pkg.sv
// acc_skip_pkg: frame constants and FSM encoding shared by the skip-record reporter
package acc_skip_pkg;
  localparam logic [15:0] HDR_WORD  = 16'h55AA;
  localparam logic [15:0] TYPE_WORD = 16'h00A5;
  localparam logic [15:0] TRL_WORD  = 16'hA55A;
  localparam int HDR_WORDS = 6;
  localparam int REC_WORDS = 4;
  localparam int TRL_WORDS = 3;
  localparam int SER_MAX   = 6;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_CHK, S_RD, S_CAP, S_DATA, S_TRL} state_t;
endpackage

// File: rtl/acc_skip_word_ser.sv
// acc_skip_word_ser: N:1 word serializer with valid/ready hold; word 0 goes out first
module acc_skip_word_ser
  import acc_skip_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     start,
  input  logic [2:0]               len,
  input  logic [SER_MAX-1:0][15:0] words,
  input  logic                     rdy,
  output logic                     vld,
  output logic [15:0]              data,
  output logic [2:0]               idx,
  output logic                     last_xfer
);
  logic last;
  assign last      = idx == len - 3'd1;
  assign last_xfer = vld && rdy && last;
  assign data      = vld ? words[idx] : '0;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      vld <= 1'b0;
      idx <= '0;
    end else if (start) begin
      vld <= 1'b1;
      idx <= '0;
    end else if (vld && rdy) begin
      vld <= !last;
      idx <= last ? '0 : idx + 3'd1;
    end
  end
endmodule

// File: rtl/acc_skip_reporter.sv
// acc_skip_reporter: snapshots skip counters, drains skip-record FIFO and streams a checksummed word frame
module acc_skip_reporter
  import acc_skip_pkg::*;
#(
  parameter int MAX_RECORDS = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        report_req_i,
  input  logic [31:0] acc_demo_skip_cnt_i,
  input  logic [31:0] acc_demo_addr_latch_i,
  input  logic        skip_fifo_ready_i,
  output logic        skip_fifo_rd_o,
  input  logic [63:0] skip_fifo_data_i,
  output logic [15:0] report_data_o,
  output logic        report_vld_o,
  input  logic        report_rdy_i,
  output logic        report_busy_o,
  output logic        report_done_o
);
  state_t state, state_nxt;
  logic [31:0] skip_q, addr_q;
  logic [63:0] rec_q;
  logic [15:0] rec_cnt, csum, ser_data;
  logic accept, go_rd, ser_start, ser_last, ser_vld, done_q, in_sum;
  logic [2:0] ser_len, ser_idx;
  logic [SER_MAX-1:0][15:0] ser_words;
  assign accept = state == S_IDLE && report_req_i;
  assign go_rd  = skip_fifo_ready_i && rec_cnt < 16'(MAX_RECORDS);
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= S_IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = report_req_i ? S_HDR : S_IDLE;
      S_HDR:   state_nxt = ser_last ? S_CHK : S_HDR;
      S_CHK:   state_nxt = go_rd ? S_RD : S_TRL;
      S_RD:    state_nxt = S_CAP;
      S_CAP:   state_nxt = S_DATA;
      S_DATA:  state_nxt = ser_last ? S_CHK : S_DATA;
      S_TRL:   state_nxt = ser_last ? S_IDLE : S_TRL;
      default: state_nxt = S_IDLE;
    endcase
  end
  // Each emission phase is launched one cycle early so its first word lands on state entry.
  always_comb begin
    ser_start      = accept || (state == S_CHK && !go_rd) || state == S_CAP;
    skip_fifo_rd_o = state == S_RD;
    ser_len        = state == S_HDR ? 3'(HDR_WORDS) : state == S_TRL ? 3'(TRL_WORDS) : 3'(REC_WORDS);
    ser_words      = state == S_HDR ? {skip_q[15:0], skip_q[31:16], addr_q[15:0], addr_q[31:16], TYPE_WORD, HDR_WORD}
                   : state == S_TRL ? {48'h0, csum, rec_cnt, TRL_WORD}
                   : {32'h0, rec_q[15:0], rec_q[31:16], rec_q[47:32], rec_q[63:48]};
    in_sum         = !(state == S_HDR && ser_idx == 3'd0) && !(state == S_TRL && ser_idx == 3'(TRL_WORDS - 1));
  end
  acc_skip_word_ser u_ser (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .start     (ser_start),
    .len       (ser_len),
    .words     (ser_words),
    .rdy       (report_rdy_i),
    .vld       (ser_vld),
    .data      (ser_data),
    .idx       (ser_idx),
    .last_xfer (ser_last)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      skip_q  <= '0;
      addr_q  <= '0;
      rec_q   <= '0;
      rec_cnt <= '0;
      csum    <= '0;
      done_q  <= 1'b0;
    end else begin
      if (accept) begin
        skip_q  <= acc_demo_skip_cnt_i;
        addr_q  <= acc_demo_addr_latch_i;
        rec_cnt <= '0;
        csum    <= '0;
      end
      if (state == S_CAP) begin
        rec_q   <= skip_fifo_data_i;
        rec_cnt <= rec_cnt + 16'd1;
      end
      if (ser_vld && report_rdy_i && in_sum) csum <= csum + ser_data;
      done_q <= state == S_TRL && ser_last;
    end
  end
  assign report_data_o = ser_data;
  assign report_vld_o  = ser_vld;
  assign report_busy_o = state != S_IDLE;
  assign report_done_o = done_q;
endmodule

// File: tb/tb_acc_skip_reporter.sv
// tb_acc_skip_reporter: directed frame checks with a FIFO model and word collector
module tb_acc_skip_reporter;
  logic clk_i = 1'b0, rst_n_i = 1'b0, report_req_i = 1'b0, skip_fifo_ready_i = 1'b0, report_rdy_i = 1'b1;
  logic [31:0] acc_demo_skip_cnt_i = '0, acc_demo_addr_latch_i = '0;
  logic [63:0] skip_fifo_data_i = '0;
  logic skip_fifo_rd_o, report_vld_o, report_busy_o, report_done_o;
  logic [15:0] report_data_o;
  int checks = 0, fails = 0;
  int strobes = 0, bad_strobes = 0, dones = 0, stall_errs = 0;
  int s0, d0;
  logic prev_rd = 1'b0, prev_stall = 1'b0, rand_rdy = 1'b0;
  logic [15:0] prev_data = '0, sum = '0;
  logic [63:0] fifo_q[$];
  logic [15:0] rx_q[$], exp_q[$];

  acc_skip_reporter #(.MAX_RECORDS(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .report_req_i(report_req_i),
    .acc_demo_skip_cnt_i(acc_demo_skip_cnt_i), .acc_demo_addr_latch_i(acc_demo_addr_latch_i),
    .skip_fifo_ready_i(skip_fifo_ready_i), .skip_fifo_rd_o(skip_fifo_rd_o), .skip_fifo_data_i(skip_fifo_data_i),
    .report_data_o(report_data_o), .report_vld_o(report_vld_o), .report_rdy_i(report_rdy_i),
    .report_busy_o(report_busy_o), .report_done_o(report_done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (skip_fifo_rd_o) begin
      strobes <= strobes + 1;
      if (prev_rd) bad_strobes <= bad_strobes + 1;
      if (fifo_q.size() != 0) skip_fifo_data_i <= fifo_q.pop_front();
    end
    prev_rd <= skip_fifo_rd_o;
  end

  always @(negedge clk_i) begin
    skip_fifo_ready_i <= fifo_q.size() != 0;
    if (report_done_o) dones <= dones + 1;
    if (report_vld_o && report_rdy_i) rx_q.push_back(report_data_o);
    if (prev_stall && !(report_vld_o && report_data_o == prev_data)) stall_errs <= stall_errs + 1;
    prev_stall <= report_vld_o && !report_rdy_i;
    prev_data <= report_data_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    if (rand_rdy) report_rdy_i = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!report_done_o && n < 400);
    check({tag, " done"}, 32'(report_done_o), 1);
  endtask

  task automatic request(input logic [31:0] skip, input logic [31:0] addr);
    acc_demo_skip_cnt_i = skip;
    acc_demo_addr_latch_i = addr;
    report_req_i = 1'b1;
    step();
    report_req_i = 1'b0;
  endtask

  function automatic void add(input logic [15:0] w);
    exp_q.push_back(w);
    sum = sum + w;
  endfunction

  function automatic void add_hdr(input logic [31:0] skip, input logic [31:0] addr);
    exp_q.push_back(16'h55AA);
    sum = '0;
    add(16'h00A5); add(addr[31:16]); add(addr[15:0]); add(skip[31:16]); add(skip[15:0]);
  endfunction

  function automatic void add_rec(input logic [63:0] r);
    add(r[63:48]); add(r[47:32]); add(r[31:16]); add(r[15:0]);
  endfunction

  function automatic void add_trl(input logic [15:0] n);
    add(16'hA55A); add(n);
    exp_q.push_back(sum);
  endfunction

  task automatic cmp_frame(input string tag);
    int sz = rx_q.size();
    check({tag, " length"}, 32'(sz), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s word%0d", tag, i), i < sz ? {16'h0, rx_q[i]} : 32'hxxxx_xxxx, {16'h0, exp_q[i]});
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic check_first(input string tag);
    check({tag, " busy"}, 32'(report_busy_o), 1);
    check({tag, " vld"}, 32'(report_vld_o), 1);
    check({tag, " first word"}, {16'h0, report_data_o}, 32'h55AA);
  endtask

  initial begin
    logic [63:0] r[6];
    r = '{64'h1000_0005_0001_2345, 64'h1001_0006_0002_3456, 64'h2002_0007_0003_4567,
          64'h3003_0008_0004_5678, 64'h4004_0009_0005_6789, 64'h5005_000A_0006_789A};
    repeat (3) step();
    check("rst vld", 32'(report_vld_o), 0);
    check("rst data", {16'h0, report_data_o}, 0);
    check("rst busy", 32'(report_busy_o), 0);
    check("rst done", 32'(report_done_o), 0);
    check("rst rd", 32'(skip_fifo_rd_o), 0);
    rst_n_i = 1'b1;
    step();

    request(32'h0000_0000, 32'h0010_0003);
    check_first("t1");
    wait_done("t1");
    check("t1 checksum", rx_q.size() == 9 ? {16'h0, rx_q[8]} : 32'hxxxx_xxxx, 32'hA612);
    step();
    check("t1 done pulse", 32'(dones), 1);
    check("t1 done width", 32'(report_done_o), 0);
    check("t1 idle", 32'(report_busy_o), 0);
    add_hdr(32'h0000_0000, 32'h0010_0003); add_trl(16'd0);
    cmp_frame("t1");

    s0 = strobes;
    fifo_q.push_back(r[0]); fifo_q.push_back(r[1]);
    request(32'h0000_0017, 32'h0020_0041);
    wait_done("t2");
    step();
    check("t2 strobes", 32'(strobes - s0), 2);
    check("t2 strobe width", 32'(bad_strobes), 0);
    add_hdr(32'h0000_0017, 32'h0020_0041); add_rec(r[0]); add_rec(r[1]); add_trl(16'd2);
    cmp_frame("t2");

    s0 = strobes;
    for (int i = 0; i < 6; i++) fifo_q.push_back(r[i]);
    request(32'h0000_0100, 32'h0004_0007);
    wait_done("t3");
    step();
    check("t3 strobes", 32'(strobes - s0), 4);
    check("t3 left in fifo", 32'(fifo_q.size()), 2);
    check("t3 fifo ready", 32'(skip_fifo_ready_i), 1);
    add_hdr(32'h0000_0100, 32'h0004_0007);
    for (int i = 0; i < 4; i++) add_rec(r[i]);
    add_trl(16'd4);
    cmp_frame("t3");
    request(32'h0000_0101, 32'h0004_0008);
    wait_done("t3b");
    step();
    check("t3b fifo empty", 32'(fifo_q.size()), 0);
    add_hdr(32'h0000_0101, 32'h0004_0008); add_rec(r[4]); add_rec(r[5]); add_trl(16'd2);
    cmp_frame("t3b");

    s0 = strobes;
    for (int i = 0; i < 3; i++) fifo_q.push_back(r[i + 2]);
    rand_rdy = 1'b1;
    request(32'h1234_5678, 32'h0033_00FF);
    wait_done("t4");
    rand_rdy = 1'b0;
    report_rdy_i = 1'b1;
    step();
    check("t4 stall hold", 32'(stall_errs), 0);
    check("t4 strobes", 32'(strobes - s0), 3);
    add_hdr(32'h1234_5678, 32'h0033_00FF);
    for (int i = 0; i < 3; i++) add_rec(r[i + 2]);
    add_trl(16'd3);
    cmp_frame("t4");

    d0 = dones;
    fifo_q.push_back(r[1]);
    request(32'h0000_0005, 32'h0030_0001);
    repeat (4) step();
    acc_demo_skip_cnt_i = 32'hDEAD_BEEF;
    report_req_i = 1'b1;
    step();
    report_req_i = 1'b0;
    wait_done("t5a");
    acc_demo_skip_cnt_i = 32'h0000_0009;
    acc_demo_addr_latch_i = 32'h0031_0002;
    report_req_i = 1'b1;
    step();
    report_req_i = 1'b0;
    check_first("t5b");
    wait_done("t5b");
    step();
    check("t5 done count", 32'(dones - d0), 2);
    add_hdr(32'h0000_0005, 32'h0030_0001); add_rec(r[1]); add_trl(16'd1);
    add_hdr(32'h0000_0009, 32'h0031_0002); add_trl(16'd0);
    cmp_frame("t5");

    s0 = strobes;
    for (int i = 0; i < 3; i++) fifo_q.push_back(r[i]);
    request(32'h0000_0077, 32'h0040_0005);
    for (int n = 0; n < 100 && strobes - s0 < 2; n++) step();
    check("t6 second strobe", 32'(strobes - s0), 2);
    step();
    rst_n_i = 1'b0;
    step();
    check("t6 rst vld", 32'(report_vld_o), 0);
    check("t6 rst data", {16'h0, report_data_o}, 0);
    check("t6 rst busy", 32'(report_busy_o), 0);
    check("t6 rst done", 32'(report_done_o), 0);
    check("t6 rst rd", 32'(skip_fifo_rd_o), 0);
    rst_n_i = 1'b1;
    s0 = strobes;
    repeat (5) step();
    check("t6 no strobe after rst", 32'(strobes - s0), 0);
    check("t6 still idle", 32'(report_busy_o), 0);
    check("t6 fifo left", 32'(fifo_q.size()), 1);
    rx_q.delete();
    request(32'h0000_0078, 32'h0041_0006);
    check_first("t6b");
    wait_done("t6b");
    step();
    add_hdr(32'h0000_0078, 32'h0041_0006); add_rec(r[2]); add_trl(16'd1);
    cmp_frame("t6b");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
